// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end feeding the decode (ID) registers.
//   Issues one outstanding request at a time to instruction memory, loads
//   returned words into ID, parks a word in a one-entry buffer when decode
//   stalls, and drains any in-flight request after a redirect.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   imem_req/addr     request to instruction memory (held until imem_ack)
//   imem_ack/rdata    memory response for the current request
//   stall             decode cannot accept; ID outputs hold
//   flush/redirect_pc branch/jump redirect; kills ID and in-flight fetch
//   id_valid/pc/instr ID stage payload
//   id_imm/ext_type   immediate field and extender type, decoded from id_instr
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [15:0] id_imm,
  output logic [1:0]  id_ext_type
);

  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fword_t;

  state_t      state;
  logic [31:0] pc;
  fword_t      buf_q;   // valid exactly while in HOLD
  fword_t      id_q;

  logic [31:0] pc_inc;
  logic [31:0] redir;
  logic        load;

  assign pc_inc = pc + 32'd4;               // wraps modulo 2^32
  assign redir  = redirect_pc & 32'hFFFF_FFFC;
  assign load   = !id_valid || !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= PC0;
      imem_req  <= 1'b0;
      imem_addr <= PC0;
      id_valid  <= 1'b0;
      id_q      <= '0;
      buf_q     <= '0;
    end else begin
      // Decode consumes the current word whenever it is not stalled; any
      // load below overrides this with a fresh valid word.
      if (!stall) id_valid <= 1'b0;

      if (flush) begin
        id_valid <= 1'b0;
        pc       <= redir;
        case (state)
          FETCH, DRAIN: begin
            if (imem_ack) begin
              // Returned word belongs to the old path: drop it.
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= redir;
            end else begin
              // Request cannot be withdrawn; keep old address until ack.
              state <= DRAIN;
            end
          end
          default: begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= redir;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          FETCH: begin
            if (imem_ack) begin
              pc        <= pc_inc;
              imem_addr <= pc_inc;
              if (load) begin
                id_q     <= '{pc: pc, instr: imem_rdata};
                id_valid <= 1'b1;
              end else begin
                buf_q    <= '{pc: pc, instr: imem_rdata};
                state    <= HOLD;
                imem_req <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              id_q      <= buf_q;
              id_valid  <= 1'b1;
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          DRAIN: begin
            if (imem_ack) begin
              state     <= FETCH;
              imem_addr <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign id_pc       = id_q.pc;
  assign id_instr    = id_q.instr;
  assign id_imm      = id_q.instr[15:0];
  // ANDI/ORI/XORI take a zero-extended immediate; everything else signed.
  assign id_ext_type = (id_q.instr[31:26] == 6'h0C || id_q.instr[31:26] == 6'h0D ||
                        id_q.instr[31:26] == 6'h0E) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack, stall, flush;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_instr;
  logic [15:0] id_imm;
  logic [1:0]  id_ext_type;
  logic        req2, vld2;
  logic [31:0] addr2, pc2, instr2;
  logic [15:0] imm2;
  logic [1:0]  ext2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_imm(id_imm), .id_ext_type(id_ext_type)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .id_valid(vld2), .id_pc(pc2),
    .id_instr(instr2), .id_imm(imm2), .id_ext_type(ext2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b1; stall = 1'b0; flush = 1'b0;
    imem_rdata = 32'h3402_8001; redirect_pc = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
      failures++; $display("FAIL rst_id got=%b/%h/%h exp=0/0/0", id_valid, id_pc, id_instr); end
    checks++; if (id_imm !== 16'h0 || id_ext_type !== 2'b00) begin
      failures++; $display("FAIL rst_imm got=%h/%b exp=0/00", id_imm, id_ext_type); end
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_addr_wrap got=%h exp=fffffffc", addr2); end
  endtask

  task automatic test_stream();
    rst = 1'b1;               // ack already high: must be ignored in IDLE
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      failures++; $display("FAIL first_req got=%b/%h/%b exp=1/0/0", imem_req, imem_addr, id_valid); end
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%h exp=fffffffc", addr2); end
    tick();
    checks++; if (imem_addr !== 32'h4 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
      failures++; $display("FAIL ori_load got=%h/%b/%h exp=4/1/0", imem_addr, id_valid, id_pc); end
    checks++; if (id_imm !== 16'h8001 || id_ext_type !== 2'b11) begin
      failures++; $display("FAIL ori_ext got=%h/%b exp=8001/11", id_imm, id_ext_type); end
    checks++; if (addr2 !== 32'h0 || req2 !== 1'b1) begin failures++; $display("FAIL wrap_second got=%h exp=0", addr2); end
    imem_rdata = 32'h2002_FFFF;
    tick();
    checks++; if (imem_addr !== 32'h8 || id_pc !== 32'h4 || id_instr !== 32'h2002_FFFF) begin
      failures++; $display("FAIL addi_load got=%h/%h/%h exp=8/4/2002ffff", imem_addr, id_pc, id_instr); end
    checks++; if (id_imm !== 16'hFFFF || id_ext_type !== 2'b00) begin
      failures++; $display("FAIL addi_ext got=%h/%b exp=ffff/00", id_imm, id_ext_type); end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; imem_rdata = 32'h3000_1234;   // ANDI at pc 8
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0 || id_pc !== 32'h4 || id_instr !== 32'h2002_FFFF || id_valid !== 1'b1) begin
      failures++; $display("FAIL hold_enter got=%b/%h/%h exp=0/4/2002ffff", imem_req, id_pc, id_instr); end
    tick();
    checks++; if (imem_req !== 1'b0 || id_pc !== 32'h4) begin
      failures++; $display("FAIL hold_stay got=%b/%h exp=0/4", imem_req, id_pc); end
    stall = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h3000_1234 || id_ext_type !== 2'b11) begin
      failures++; $display("FAIL hold_release got=%b/%h/%h/%b exp=1/8/30001234/11", id_valid, id_pc, id_instr, id_ext_type); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      failures++; $display("FAIL resume_addr got=%b/%h exp=1/c", imem_req, imem_addr); end
  endtask

  task automatic test_flush_drain();
    flush = 1'b1; redirect_pc = 32'h0000_0100;   // ack still low
    tick();
    flush = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || id_valid !== 1'b0) begin
      failures++; $display("FAIL drain_enter got=%b/%h/%b exp=1/c/0", imem_req, imem_addr, id_valid); end
    tick();
    checks++; if (imem_addr !== 32'hC || id_valid !== 1'b0) begin
      failures++; $display("FAIL drain_wait got=%h/%b exp=c/0", imem_addr, id_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      failures++; $display("FAIL drain_exit got=%b/%h/%b exp=1/100/0", imem_req, imem_addr, id_valid); end
    tick();
    checks++; if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      failures++; $display("FAIL redirect_wait got=%h/%b exp=100/0", imem_addr, id_valid); end
  endtask

  task automatic test_flush_stall();
    imem_ack = 1'b1; imem_rdata = 32'h3402_0005;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || imem_addr !== 32'h104) begin
      failures++; $display("FAIL redirect_load got=%b/%h/%h exp=1/100/104", id_valid, id_pc, imem_addr); end
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h0000_0203;   // low bits must be dropped
    tick();
    flush = 1'b0; stall = 1'b0; imem_rdata = 32'h2008_0010;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++; $display("FAIL flush_stall got=%b/%b/%h exp=0/1/200", id_valid, imem_req, imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h2008_0010) begin
      failures++; $display("FAIL flush_stall_next got=%b/%h/%h exp=1/200/20080010", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_flush_hold();
    stall = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    checks++; if (imem_req !== 1'b0 || id_pc !== 32'h200) begin
      failures++; $display("FAIL hold2_enter got=%b/%h exp=0/200", imem_req, id_pc); end
    flush = 1'b1; redirect_pc = 32'h0000_0300; imem_ack = 1'b0;
    tick();
    flush = 1'b0; stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3822_0000;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      failures++; $display("FAIL hold_flush got=%b/%b/%h exp=0/1/300", id_valid, imem_req, imem_addr); end
    tick();
    checks++; if (id_pc !== 32'h300 || id_instr !== 32'h3822_0000 || id_ext_type !== 2'b11) begin
      failures++; $display("FAIL hold_flush_next got=%h/%h/%b exp=300/38220000/11", id_pc, id_instr, id_ext_type); end
    checks++; if (imem_addr !== 32'h304) begin failures++; $display("FAIL hold_flush_addr got=%h exp=304", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_flush_drain();
    test_flush_stall();
    test_flush_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserts immediately, releases on clk edge.
REQ-004 imem_req  output  1  instruction memory request.
REQ-005 imem_addr  output  32  fetch address; equals pc while imem_req high.
REQ-006 imem_ack  input  1  imem_rdata valid; response to current request.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  decode cannot accept; ID outputs shall hold.
REQ-009 flush  input  1  branch/jump redirect; kills ID and in-flight fetch.
REQ-010 redirect_pc  input  32  new pc, sampled only when flush=1.
REQ-011 id_valid  output  1  ID outputs hold a live instruction.
REQ-012 id_pc  output  32  address of id_instr.
REQ-013 id_instr  output  32  instruction to decode.
REQ-014 id_imm  output  16  id_instr[15:0], feeds immediate extender data_in.
REQ-015 id_ext_type  output  2  extender type: 2'b11 zero-extend, 2'b00 sign-extend.

Function
REQ-016 States SHALL be IDLE, FETCH, HOLD, DRAIN.
REQ-017 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-018 FETCH: imem_req=1, imem_addr=pc; imem_req/imem_addr held stable until imem_ack (no withdrawal).
REQ-019 ID load condition: load = !id_valid || !stall.
REQ-020 FETCH, imem_ack=1, flush=0, load=1: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, stay FETCH.
REQ-021 FETCH, imem_ack=1, flush=0, load=0: word into one-entry buffer (instr, pc), pc<=pc+4, go HOLD.
REQ-022 HOLD: imem_req=0; when stall=0, buffer moves to ID regs, id_valid<=1, go FETCH.
REQ-023 ID consumed (stall=0) with no new load: id_valid<=0.
REQ-024 id_ext_type=2'b11 when id_instr[31:26] is 6'h0C, 6'h0D or 6'h0E (ANDI/ORI/XORI); else 2'b00; id_imm=id_instr[15:0]; both derived from registered id_instr.
REQ-025 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc[1:0] forced to 2'b00, including redirect_pc.
REQ-026 flush has priority over stall, ack and all state actions.
REQ-027 flush in any state: id_valid<=0, buffer discarded, pc<=redirect_pc.
REQ-028 flush in FETCH with imem_ack=0: go DRAIN; imem_req and old imem_addr held until ack.
REQ-029 flush in FETCH with imem_ack=1: returned word discarded, go FETCH at redirect_pc next cycle.
REQ-030 flush in IDLE or HOLD: go FETCH.
REQ-031 DRAIN: on imem_ack, word discarded, go FETCH; second flush in DRAIN overwrites pc, stays DRAIN.
REQ-032 No instruction SHALL ever be duplicated or skipped in ID absent flush.

Reset
REQ-033 While rst=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0, id_imm=0, id_ext_type=2'b00, buffer empty.
REQ-034 rst asserted mid-transaction aborts it; pending ack after release ignored until first FETCH request.

Verification
REQ-035 Reset release, ack every cycle, rdata 32'h3402_8001 (ORI) -> imem_addr 0,4,8; id_pc=0, id_imm=16'h8001, id_ext_type=2'b11 two cycles after release.
REQ-036 Word 32'h2002_FFFF (ADDI) -> id_ext_type=2'b00, id_imm=16'hFFFF.
REQ-037 stall=1 with id_valid=1 while ack returns word at pc 8 -> HOLD, imem_req=0, ID unchanged; stall=0 -> id_pc=8 next cycle, fetch resumes at 12.
REQ-038 flush with redirect_pc=32'h0000_0100 during 3-cycle memory wait -> imem_addr held until ack, word dropped, next request addr 32'h100, id_valid=0 meanwhile.
REQ-039 flush and stall same cycle -> id_valid=0 next cycle, pc=redirect_pc.
REQ-040 RESET_PC=32'hFFFF_FFFC, ack every cycle -> second request addr 32'h0000_0000.
